// File: rtl/firstn_interleave_mux.sv
// firstn_interleave_mux
// Drives NENG cluster-finder engines in round-robin. One engine is strobed
// per frame of PHASES clock4x cycles. Each engine's result is captured
// ENG_LAT+1 edges after its strobe and forwarded with the frame number of
// that strobe.
//
// Ports:
//   clock4x      - sole clock, all state on the rising edge
//   global_reset - asynchronous, active-high reset
//   eng_adr      - flattened engine addresses, engine e / cluster i at (e*NCLUST+i)*ADRB
//   eng_cnt      - flattened engine counts, same ordering
//   latch_out    - one-hot latch strobe, one engine per frame
//   adr_out      - selected cluster addresses (all-ones = empty cluster)
//   cnt_out      - selected cluster counts
//   valid_out    - one-cycle pulse marking a new result
//   n_clust      - number of non-empty clusters in the current result
//   bx_out       - frame number of the latch that produced the current result
module firstn_interleave_mux #(
  parameter int NENG    = 2,
  parameter int NCLUST  = 8,
  parameter int ADRB    = 11,
  parameter int CNTB    = 3,
  parameter int PHASES  = 8,
  parameter int ENG_LAT = 6,
  parameter int BXB     = 12,
  parameter int HOLD    = 1
) (
  input  logic                              clock4x,
  input  logic                              global_reset,
  input  logic [NENG*NCLUST*ADRB-1:0]       eng_adr,
  input  logic [NENG*NCLUST*CNTB-1:0]       eng_cnt,
  output logic [NENG-1:0]                   latch_out,
  output logic [NCLUST*ADRB-1:0]            adr_out,
  output logic [NCLUST*CNTB-1:0]            cnt_out,
  output logic                              valid_out,
  output logic [$clog2(NCLUST+1)-1:0]       n_clust,
  output logic [BXB-1:0]                    bx_out
);

  localparam int PHB   = (PHASES > 1) ? $clog2(PHASES) : 1;
  localparam int SELB  = (NENG > 1) ? $clog2(NENG) : 1;
  localparam int NB    = $clog2(NCLUST + 1);
  localparam int DEPTH = ENG_LAT + 1;
  localparam logic [NCLUST*ADRB-1:0] EMPTY_ADR = {(NCLUST*ADRB){1'b1}};

  // Reject parameter sets where the capture of one engine would collide with
  // its own next strobe, or where the phase counter cannot wrap naturally.
  generate
    if (NENG < 2 || NENG > 8) begin : g_bad_neng
      $error("firstn_interleave_mux: NENG must be in 2..8");
    end
    if (PHASES < 2 || (PHASES & (PHASES - 1)) != 0) begin : g_bad_phases
      $error("firstn_interleave_mux: PHASES must be a power of 2 and >= 2");
    end
    if (NENG * PHASES <= ENG_LAT + 1) begin : g_bad_lat
      $error("firstn_interleave_mux: NENG*PHASES must exceed ENG_LAT+1");
    end
  endgenerate

  logic [PHB-1:0]  phase_reg;
  logic [BXB-1:0]  frame_reg;
  logic [SELB-1:0] sel_reg;

  // Latch-request delay line: entry k holds the request issued k+1 edges ago.
  logic [DEPTH-1:0]           pipe_vld;
  logic [SELB-1:0]            pipe_sel   [DEPTH];
  logic [BXB-1:0]             pipe_frame [DEPTH];

  logic                       latch_now;
  logic                       capture;
  logic [SELB-1:0]            cap_sel;
  logic [NCLUST*ADRB-1:0]     adr_sel;
  logic [NCLUST*CNTB-1:0]     cnt_sel;
  logic [NCLUST-1:0]          nonempty;
  logic [NB-1:0]              n_sel;

  assign latch_now = (phase_reg == '0);
  assign capture   = pipe_vld[DEPTH-1];
  assign cap_sel   = pipe_sel[DEPTH-1];

  // Slice out the engine whose result matures on this edge.
  always_comb begin
    adr_sel = '0;
    cnt_sel = '0;
    for (int e = 0; e < NENG; e++) begin
      if (cap_sel == SELB'(e)) begin
        adr_sel = eng_adr[e*NCLUST*ADRB +: NCLUST*ADRB];
        cnt_sel = eng_cnt[e*NCLUST*CNTB +: NCLUST*CNTB];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NCLUST; gi++) begin : g_flag
      assign nonempty[gi] = (adr_sel[gi*ADRB +: ADRB] != {ADRB{1'b1}});
    end
  endgenerate

  always_comb begin
    n_sel = '0;
    for (int i = 0; i < NCLUST; i++) begin
      n_sel = n_sel + NB'(nonempty[i]);
    end
  end

  // Frame timing and round-robin engine strobes.
  always_ff @(posedge clock4x or posedge global_reset) begin
    if (global_reset) begin
      phase_reg <= '0;
      frame_reg <= '0;
      sel_reg   <= '0;
      latch_out <= '0;
    end else begin
      latch_out <= latch_now ? (NENG'(1) << sel_reg) : '0;
      if (phase_reg == PHB'(PHASES - 1)) begin
        phase_reg <= '0;
        frame_reg <= frame_reg + BXB'(1);
        sel_reg   <= (sel_reg == SELB'(NENG - 1)) ? '0 : sel_reg + SELB'(1);
      end else begin
        phase_reg <= phase_reg + PHB'(1);
      end
    end
  end

  always_ff @(posedge clock4x or posedge global_reset) begin
    if (global_reset) begin
      pipe_vld <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        pipe_sel[k]   <= '0;
        pipe_frame[k] <= '0;
      end
    end else begin
      pipe_vld[0]   <= latch_now;
      pipe_sel[0]   <= sel_reg;
      pipe_frame[0] <= frame_reg;
      for (int k = 1; k < DEPTH; k++) begin
        pipe_vld[k]   <= pipe_vld[k-1];
        pipe_sel[k]   <= pipe_sel[k-1];
        pipe_frame[k] <= pipe_frame[k-1];
      end
    end
  end

  // Result capture; without HOLD the outputs fall back to empty right after
  // the valid cycle, while bx_out always keeps the last frame number.
  always_ff @(posedge clock4x or posedge global_reset) begin
    if (global_reset) begin
      valid_out <= 1'b0;
      adr_out   <= EMPTY_ADR;
      cnt_out   <= '0;
      n_clust   <= '0;
      bx_out    <= '0;
    end else begin
      valid_out <= capture;
      if (capture) begin
        adr_out <= adr_sel;
        cnt_out <= cnt_sel;
        n_clust <= n_sel;
        bx_out  <= pipe_frame[DEPTH-1];
      end else if (HOLD == 0) begin
        adr_out <= EMPTY_ADR;
        cnt_out <= '0;
        n_clust <= '0;
      end
    end
  end

endmodule

// File: tb/tb_firstn_interleave_mux.sv
// Bench for firstn_interleave_mux at default parameters; a HOLD=1 and a
// HOLD=0 instance share the same engine inputs. Expected outputs come from
// the edge count since reset release using frame arithmetic.
module tb_firstn_interleave_mux;
  localparam int NENG = 2, NCLUST = 8, ADRB = 11, CNTB = 3;
  localparam int PHASES = 8, ENG_LAT = 6, BXB = 12;
  localparam int AW = NENG*NCLUST*ADRB, CW = NENG*NCLUST*CNTB;
  localparam int OAW = NCLUST*ADRB, OCW = NCLUST*CNTB;
  localparam logic [OAW-1:0] EMPTY = '1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [AW-1:0] eng_adr;
  logic [CW-1:0] eng_cnt;

  logic [NENG-1:0] h_latch, z_latch;
  logic [OAW-1:0]  h_adr, z_adr;
  logic [OCW-1:0]  h_cnt, z_cnt;
  logic            h_valid, z_valid;
  logic [3:0]      h_n, z_n;
  logic [BXB-1:0]  h_bx, z_bx;

  firstn_interleave_mux #(.HOLD(1)) dut_hold (
    .clock4x(clk), .global_reset(rst), .eng_adr(eng_adr), .eng_cnt(eng_cnt),
    .latch_out(h_latch), .adr_out(h_adr), .cnt_out(h_cnt), .valid_out(h_valid),
    .n_clust(h_n), .bx_out(h_bx));

  firstn_interleave_mux #(.HOLD(0)) dut_nohold (
    .clock4x(clk), .global_reset(rst), .eng_adr(eng_adr), .eng_cnt(eng_cnt),
    .latch_out(z_latch), .adr_out(z_adr), .cnt_out(z_cnt), .valid_out(z_valid),
    .n_clust(z_n), .bx_out(z_bx));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int t = 0;

  // reference state
  logic [NENG-1:0] e_latch;
  logic            e_valid;
  logic [OAW-1:0]  h_eadr, z_eadr;
  logic [OCW-1:0]  h_ecnt, z_ecnt;
  int              h_en, z_en;
  logic [BXB-1:0]  h_ebx, z_ebx;
  logic [AW-1:0]   in_adr;
  logic [CW-1:0]   in_cnt;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
    end
  endtask

  task automatic reset_model();
    e_latch = '0; e_valid = 1'b0;
    h_eadr = EMPTY; z_eadr = EMPTY;
    h_ecnt = '0; z_ecnt = '0;
    h_en = 0; z_en = 0;
    h_ebx = '0; z_ebx = '0;
  endtask

  // Frame arithmetic: edge t (t>=1) latches when (t-1) is a multiple of
  // PHASES; a latch at edge L is captured at edge L+ENG_LAT+1.
  task automatic model_edge();
    int k, eng, n;
    logic [OAW-1:0] a;
    logic [OCW-1:0] c;
    e_latch = ((t-1) % PHASES == 0) ? NENG'(1 << (((t-1) / PHASES) % NENG)) : '0;
    e_valid = (t >= ENG_LAT + 2) && ((t - ENG_LAT - 2) % PHASES == 0);
    if (e_valid) begin
      k   = (t - ENG_LAT - 2) / PHASES;
      eng = k % NENG;
      a   = in_adr[eng*OAW +: OAW];
      c   = in_cnt[eng*OCW +: OCW];
      n   = 0;
      for (int i = 0; i < NCLUST; i++) if (a[i*ADRB +: ADRB] != 11'h7FF) n++;
      h_eadr = a; z_eadr = a;
      h_ecnt = c; z_ecnt = c;
      h_en = n; z_en = n;
      h_ebx = BXB'(k % (1 << BXB)); z_ebx = h_ebx;
    end else begin
      z_eadr = EMPTY; z_ecnt = '0; z_en = 0;
    end
  endtask

  task automatic check_all(input string w);
    chk({w, " h_latch"}, 128'(h_latch), 128'(e_latch));
    chk({w, " h_valid"}, 128'(h_valid), 128'(e_valid));
    chk({w, " h_adr"},   128'(h_adr),   128'(h_eadr));
    chk({w, " h_cnt"},   128'(h_cnt),   128'(h_ecnt));
    chk({w, " h_n"},     128'(h_n),     128'(h_en));
    chk({w, " h_bx"},    128'(h_bx),    128'(h_ebx));
    chk({w, " z_latch"}, 128'(z_latch), 128'(e_latch));
    chk({w, " z_valid"}, 128'(z_valid), 128'(e_valid));
    chk({w, " z_adr"},   128'(z_adr),   128'(z_eadr));
    chk({w, " z_cnt"},   128'(z_cnt),   128'(z_ecnt));
    chk({w, " z_n"},     128'(z_n),     128'(z_en));
    chk({w, " z_bx"},    128'(z_bx),    128'(z_ebx));
  endtask

  task automatic set_cluster(input int e, input int i, input int a, input int c);
    eng_adr[(e*NCLUST+i)*ADRB +: ADRB] = ADRB'(a);
    eng_cnt[(e*NCLUST+i)*CNTB +: CNTB] = CNTB'(c);
  endtask

  task automatic set_directed();
    eng_adr = '1;
    eng_cnt = '0;
    set_cluster(0, 0, 5, 1);
    set_cluster(0, 1, 100, 2);
    set_cluster(0, 2, 1535, 7);
  endtask

  task automatic randomize_inputs();
    for (int e = 0; e < NENG; e++)
      for (int i = 0; i < NCLUST; i++)
        if ($urandom_range(1, 0) == 0) set_cluster(e, i, 2047, 0);
        else set_cluster(e, i, int'($urandom_range(2046, 0)), int'($urandom_range(7, 1)));
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input bit rnd);
    if (rnd) randomize_inputs();
    in_adr = eng_adr;
    in_cnt = eng_cnt;
    @(posedge clk);
    t++;
    model_edge();
    #1;
    $display("edge t=%0d latch=%b valid=%b n=%0d bx=%0d", t, h_latch, h_valid, h_n, h_bx);
    check_all("run");
    @(negedge clk);
  endtask

  task automatic do_reset(input string w);
    rst = 1'b1;
    #1;
    reset_model();
    check_all({w, "_async"});
    @(negedge clk);
    rst = 1'b0;
    t = 0;
    check_all({w, "_release"});
  endtask

  initial begin
    set_directed();
    #2 rst = 1'b1;
    #1;
    reset_model();
    check_all("por");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    t = 0;
    check_all("release");

    // directed frames: engine0 carries three clusters, engine1 is empty
    for (int s = 0; s < 17; s++) begin
      step(1'b0);
      if (t == 8) begin
        chk("e8_n_clust", 128'(h_n), 128'(3));
        chk("e8_adr_low", 128'(h_adr[32:0]), 128'({11'd1535, 11'd100, 11'd5}));
        chk("e8_cnt_low", 128'(h_cnt[8:0]), 128'({3'd7, 3'd2, 3'd1}));
      end
      if (t == 9) begin
        chk("e9_nohold_adr", 128'(z_adr), 128'(EMPTY));
        chk("e9_nohold_bx", 128'(z_bx), 128'(0));
        chk("e9_hold_n", 128'(h_n), 128'(3));
      end
      if (t == 16) begin
        chk("e16_n_clust", 128'(h_n), 128'(0));
        chk("e16_bx", 128'(h_bx), 128'(1));
      end
    end

    // randomized engine data, changing every cycle
    for (int s = 0; s < 60; s++) step(1'b1);

    // reset while the first latch is still in flight
    do_reset("rst_a");
    for (int s = 0; s < 5; s++) step(1'b1);
    do_reset("rst_mid");
    for (int s = 0; s < 40; s++) step(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
